// File: rtl/rv_isa_pkg.sv
// RV32 opcode constants and immediate-format encoding shared by the decode/extend
// path and the instruction encoder.
package rv_isa_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } imm_fmt_e;

    typedef struct packed {
        logic     legal;
        imm_fmt_e fmt;
    } op_dec_t;

    function automatic op_dec_t op_to_fmt(input logic [6:0] op);
        op_dec_t d;
        d.legal = 1'b1;
        d.fmt   = FMT_I;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: d.fmt = FMT_I;
            OP_STORE:                 d.fmt = FMT_S;
            OP_BRANCH:                d.fmt = FMT_B;
            OP_JAL:                   d.fmt = FMT_J;
            default:                  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder; the slave side is the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_illegal;
    logic              err_imm;
    logic [15:0]       word_count;

    modport master (
        output in_valid, op, rd, rs1, rs2, funct3, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_illegal, err_imm, word_count
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, funct3, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_illegal, err_imm, word_count
    );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field packer: scatters the immediate into its format's bit slots
// and reports whether the immediate fits that format.
module imm_pack
    import rv_isa_pkg::*;
(
    input  imm_fmt_e    fmt,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        range_ok
);

    // Immediate fits when every bit above the top encoded bit copies that bit.
    logic fits12, fits13, fits21;

    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits13 = (imm[31:12] == {20{imm[12]}});
    assign fits21 = (imm[31:20] == {12{imm[20]}});

    always_comb begin
        instr    = 32'h0;
        range_ok = 1'b0;
        case (fmt)
            FMT_I: begin
                instr    = {imm[11:0], rs1, funct3, rd, op};
                range_ok = fits12;
            end
            FMT_S: begin
                instr    = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                range_ok = fits12;
            end
            FMT_B: begin
                instr    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                range_ok = fits13 && !imm[0];
            end
            FMT_J: begin
                instr    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                range_ok = fits21 && !imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: one-entry registered output with valid/ready,
// running word address, saturating emit counter and sticky error flags.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        state;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       count_q;
    logic              err_illegal_q;
    logic              err_imm_q;

    op_dec_t     dec;
    logic [31:0] word;
    logic        range_ok;
    logic        accept;
    logic        drain;

    assign dec = op_to_fmt(bus.op);

    imm_pack u_pack (
        .fmt      (dec.fmt),
        .op       (bus.op),
        .rd       (bus.rd),
        .rs1      (bus.rs1),
        .rs2      (bus.rs2),
        .funct3   (bus.funct3),
        .imm      (bus.imm),
        .instr    (word),
        .range_ok (range_ok)
    );

    assign bus.in_ready = (state == EMPTY) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = (state == FULL) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            instr_q       <= 32'h0;
            addr_q        <= ADDR_W'(BASE_ADDR);
            count_q       <= 16'h0;
            err_illegal_q <= 1'b0;
            err_imm_q     <= 1'b0;
        end else begin
            // A legal accept overrides the drain so back-to-back words keep out_valid high.
            if (accept && dec.legal && range_ok) begin
                state   <= FULL;
                instr_q <= word;
            end else if (drain) begin
                state <= EMPTY;
            end
            if (drain) begin
                addr_q <= addr_q + ADDR_W'(4);
                if (count_q != 16'hFFFF)
                    count_q <= count_q + 16'd1;
            end
            if (accept && !dec.legal)
                err_illegal_q <= 1'b1;
            if (accept && dec.legal && !range_ok)
                err_imm_q <= 1'b1;
        end
    end

    assign bus.out_valid   = (state == FULL);
    assign bus.out_instr   = instr_q;
    assign bus.out_addr    = addr_q;
    assign bus.word_count  = count_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_imm     = err_imm_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed encodings and handshake checks.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(10)) bif ();

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        bif.in_valid = 1'b1;
        bif.op       = op;
        bif.rd       = rd;
        bif.rs1      = rs1;
        bif.rs2      = rs2;
        bif.funct3   = f3;
        bif.imm      = imm;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        drive(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
        bif.in_valid  = 1'b0;
        step();
        step();
        chk("rst_valid", bif.out_valid, 0);
        chk("rst_instr", bif.out_instr, 32'h0);
        chk("rst_addr", bif.out_addr, 0);
        chk("rst_errs", {bif.err_illegal, bif.err_imm}, 0);
        chk("rst_count", bif.word_count, 0);
        rst = 1'b0;

        // lw / sw / beq / jal, each accepted while the previous one drains
        drive(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8);
        #1 chk("lw_in_ready", bif.in_ready, 1);
        step();
        bif.in_valid = 1'b0;
        chk("lw_valid", bif.out_valid, 1);
        chk("lw_instr", bif.out_instr, 32'h00812283);
        chk("lw_addr", bif.out_addr, 0);

        drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 32'd12);
        step();
        chk("sw_instr", bif.out_instr, 32'h00512623);
        chk("sw_addr", bif.out_addr, 4);

        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, -32'sd8);
        step();
        chk("beq_instr", bif.out_instr, 32'hFE208CE3);
        chk("beq_addr", bif.out_addr, 8);

        drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048);
        step();
        bif.in_valid = 1'b0;
        chk("jal_instr", bif.out_instr, 32'h001000EF);
        chk("jal_addr", bif.out_addr, 12);
        chk("jal_count", bif.word_count, 3);

        // backpressure: held word stays put, nothing new accepted
        bif.out_ready = 1'b0;
        drive(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_in_ready", bif.in_ready, 0);
            step();
            chk("hold_valid", bif.out_valid, 1);
            chk("hold_instr", bif.out_instr, 32'h001000EF);
            chk("hold_addr", bif.out_addr, 12);
        end
        chk("hold_count", bif.word_count, 3);

        // reset discards the held word, then stream four words back to back
        bif.out_ready = 1'b1;
        do_reset();
        chk("rst2_valid", bif.out_valid, 0);
        chk("rst2_addr", bif.out_addr, 0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_w;
            case (k)
                0: begin drive(7'b0000011, 5'd5, 5'd2, 5'd0, 3'b010, 32'd8);  exp_w = 32'h00812283; end
                1: begin drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 32'd12); exp_w = 32'h00512623; end
                2: begin drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, -32'sd8); exp_w = 32'hFE208CE3; end
                default: begin drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048); exp_w = 32'h001000EF; end
            endcase
            #1 chk("strm_in_ready", bif.in_ready, 1);
            step();
            chk("strm_valid", bif.out_valid, 1);
            chk("strm_instr", bif.out_instr, exp_w);
            chk("strm_addr", bif.out_addr, 32'(4 * k));
        end
        bif.in_valid = 1'b0;
        step();
        chk("strm_empty", bif.out_valid, 0);
        chk("strm_count", bif.word_count, 4);
        chk("strm_next_addr", bif.out_addr, 16);

        // illegal opcode, then misaligned branch offset
        drive(7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h0);
        step();
        bif.in_valid = 1'b0;
        chk("ill_valid", bif.out_valid, 0);
        chk("ill_flag", bif.err_illegal, 1);
        chk("ill_imm_clear", bif.err_imm, 0);

        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 32'd5);
        step();
        bif.in_valid = 1'b0;
        chk("bmis_valid", bif.out_valid, 0);
        chk("bmis_flag", bif.err_imm, 1);
        step();
        chk("sticky", {bif.err_illegal, bif.err_imm}, 2'b11);
        chk("err_count", bif.word_count, 4);

        do_reset();
        chk("rst3_errs", {bif.err_illegal, bif.err_imm}, 0);

        // I-type range boundary: 2048 overflows, -2048 fits
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048);
        step();
        bif.in_valid = 1'b0;
        chk("irange_valid", bif.out_valid, 0);
        chk("irange_flag", bif.err_imm, 1);
        chk("irange_ill", bif.err_illegal, 0);

        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, -32'sd2048);
        step();
        chk("imin_valid", bif.out_valid, 1);
        chk("imin_instr", bif.out_instr, 32'h80000093);

        // dropped request while the held word drains leaves the stage empty
        drive(7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 32'h0);
        step();
        bif.in_valid = 1'b0;
        chk("drop_drain_valid", bif.out_valid, 0);
        chk("drop_drain_count", bif.word_count, 1);
        chk("drop_drain_addr", bif.out_addr, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
